// File: rtl/asip_run_control.sv
// Run-control for the pipelined ASIP: button conditioning, run/halt/step FSM, core clock enable and reset.
// Optional PC breakpoint comparator enabled by defining RUN_CTRL_BREAKPOINT_EN.

module asip_run_control_debounce #(
    parameter int   DB_CYCLES = 4,
    parameter logic RST_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;

    // Synchronizer, run-length counter and registered falling-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= RST_VAL;
            sync2_r <= RST_VAL;
            level_r <= RST_VAL;
            fall_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            fall_r  <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r <= sync2_r;
                    fall_r  <= level_r & ~sync2_r;
                    cnt_r   <= '0;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                // Any sample matching the accepted level restarts the run
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;
endmodule

module asip_run_control #(
    parameter int N         = 24,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwr,
    input  logic             dbg,
    input  logic             stp,
    input  logic [N-1:0]     pc,
    input  logic [N-1:0]     bp_addr,
    input  logic             bp_valid,
    output logic             en,
    output logic             core_rst,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);
    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             pwr_p_s;
    logic             stp_p_s;
    logic             dbg_l_s;
    logic             bp_hit_s;
    logic             en_s;
    logic             core_rst_r;
    logic             halted_r;
    logic [CNT_W-1:0] cycle_cnt_r;
    logic             pwr_l_unused_s;
    logic             stp_l_unused_s;
    logic             dbg_f_unused_s;

    asip_run_control_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_pwr (
        .clk(clk), .rst(rst), .raw(pwr), .level(pwr_l_unused_s), .fall(pwr_p_s)
    );
    asip_run_control_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_stp (
        .clk(clk), .rst(rst), .raw(stp), .level(stp_l_unused_s), .fall(stp_p_s)
    );
    asip_run_control_debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_dbg (
        .clk(clk), .rst(rst), .raw(dbg), .level(dbg_l_s), .fall(dbg_f_unused_s)
    );

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic skip_r;

    // skip masks the breakpoint for the first RUN cycle so a resume at bp_addr advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_r <= 1'b0;
        end else if ((state_next_s == ST_RUN) && (state_r != ST_RUN)) begin
            skip_r <= 1'b1;
        end else if (state_r == ST_RUN) begin
            skip_r <= 1'b0;
        end else begin
            skip_r <= skip_r;
        end
    end

    assign bp_hit_s = bp_valid & (pc == bp_addr) & (state_r == ST_RUN) & ~skip_r;
`else
    logic bp_unused_s;
    assign bp_unused_s = ^{pc, bp_addr, bp_valid};
    assign bp_hit_s    = 1'b0;
`endif

    // Next-state logic; the first matching condition in each state wins
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (pwr_p_s) begin
                    state_next_s = dbg_l_s ? ST_HALT : ST_RUN;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_RUN: begin
                if (pwr_p_s) begin
                    state_next_s = ST_OFF;
                end else if (dbg_l_s || bp_hit_s) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (pwr_p_s) begin
                    state_next_s = ST_OFF;
                end else if (!dbg_l_s) begin
                    state_next_s = ST_RUN;
                end else if (stp_p_s) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_STEP: begin
                if (pwr_p_s) begin
                    state_next_s = ST_OFF;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: state_next_s = ST_OFF;
        endcase
    end

    // Clock enable: the breakpoint cycle is suppressed so the core stops before bp_addr
    always_comb begin
        en_s = 1'b0;
        case (state_r)
            ST_STEP: en_s = 1'b1;
            ST_RUN:  en_s = ~bp_hit_s;
            default: en_s = 1'b0;
        endcase
    end

    // State register plus outputs derived from the next state so they align with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_OFF;
            core_rst_r <= 1'b1;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            core_rst_r <= (state_next_s == ST_OFF);
            halted_r   <= (state_next_s == ST_HALT);
        end
    end

    // Enabled-cycle counter, cleared whenever the unit powers down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r <= '0;
        end else if ((state_next_s == ST_OFF) && (state_r != ST_OFF)) begin
            cycle_cnt_r <= '0;
        end else if (en_s) begin
            cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign en        = en_s;
    assign core_rst  = core_rst_r;
    assign state     = state_r;
    assign halted    = halted_r;
    assign cycle_cnt = cycle_cnt_r;
endmodule
